// File: rtl/cylon_scanner_pkg.sv
// ---------------------------------------------------------------------------
// cylon_scanner_pkg
// Shared definitions for the cylon scanner: scan mode encodings, the width
// of the step-rate field, and the clamp that turns a programmed step length
// into the terminal count of the step timer.
// ---------------------------------------------------------------------------
package cylon_scanner_pkg;

  localparam int STEP_W = 30;

  localparam logic [1:0] MODE_BOUNCE    = 2'd0;
  localparam logic [1:0] MODE_WRAP_UP   = 2'd1;
  localparam logic [1:0] MODE_WRAP_DOWN = 2'd2;
  localparam logic [1:0] MODE_HOLD      = 2'd3;

  // Terminal count for a step of `clks` cycles; a programmed 0 acts as 1.
  function automatic logic [STEP_W-1:0] step_limit(input logic [STEP_W-1:0] clks);
    if (clks == 30'd0) begin
      return 30'd0;
    end else begin
      return clks - 30'd1;
    end
  endfunction

endpackage

// File: rtl/cylon_scanner_step_timer.sv
// ---------------------------------------------------------------------------
// scan_step_timer
// Counts enabled cycles and flags the cycle on which a scanner step is due.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   enable    - counter advances only while high; tick is suppressed when low
//   step_clks - clocks per step (0 behaves as 1)
//   tick      - high on the enabled cycle that completes a step period
// ---------------------------------------------------------------------------
module scan_step_timer
  import cylon_scanner_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [STEP_W-1:0] step_clks,
  output logic              tick
);

  logic [STEP_W-1:0] cnt_r;
  logic [STEP_W-1:0] limit_s;

  assign limit_s = step_limit(step_clks);
  // ">=" rather than "==" so a step length lowered below the current count
  // fires immediately instead of running the counter through its full range.
  assign tick    = enable & (cnt_r >= limit_s);

  // Enabled-cycle counter, cleared on reset and on every tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 30'd0;
    end else if (tick) begin
      cnt_r <= 30'd0;
    end else if (enable) begin
      cnt_r <= cnt_r + 30'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/cylon_scanner.sv
// ---------------------------------------------------------------------------
// cylon_scanner
// Steps a single lit position across NUMBER_DEVICES outputs at a programmable
// rate, in bounce, wrap-up, wrap-down or hold mode, for the LED fader.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   enable    - 1 = run, 0 = freeze all state (step/turn low)
//   step_clks - clocks per step (0 behaves as 1)
//   mode      - 0 bounce, 1 wrap up, 2 wrap down, 3 hold (sampled on tick)
//   active    - one-hot decode of position (registered)
//   position  - current lit index
//   direction - 1 ascending, 0 descending
//   step      - one-cycle strobe when position updates
//   turn      - one-cycle strobe with step on a reversal or wrap
// ---------------------------------------------------------------------------
module cylon_scanner
  import cylon_scanner_pkg::*;
#(
  parameter int NUMBER_DEVICES = 16,
  parameter int POS_W          = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [STEP_W-1:0]         step_clks,
  input  logic [1:0]                mode,
  output logic [NUMBER_DEVICES-1:0] active,
  output logic [POS_W-1:0]          position,
  output logic                      direction,
  output logic                      step,
  output logic                      turn
);

  localparam logic [POS_W-1:0]          POS_ZERO     = {POS_W{1'b0}};
  localparam logic [POS_W-1:0]          POS_ONE      = POS_W'(1);
  localparam logic [POS_W-1:0]          LAST_POS     = POS_W'(NUMBER_DEVICES - 1);
  localparam logic [NUMBER_DEVICES-1:0] ACTIVE_RESET = NUMBER_DEVICES'(1);
  // With a single position nothing can move, reverse or wrap.
  localparam logic                      MULTI_POS    = (NUMBER_DEVICES > 1);

  logic                      tick_s;
  logic [POS_W-1:0]          pos_next_s;
  logic                      dir_next_s;
  logic                      turn_next_s;
  logic [NUMBER_DEVICES-1:0] active_next_s;

  logic [POS_W-1:0]          position_r;
  logic                      direction_r;
  logic [NUMBER_DEVICES-1:0] active_r;
  logic                      step_r;
  logic                      turn_r;

  scan_step_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .step_clks (step_clks),
    .tick      (tick_s)
  );

  // Next position/direction for the mode currently presented.
  always_comb begin
    pos_next_s  = position_r;
    dir_next_s  = direction_r;
    turn_next_s = 1'b0;
    case (mode)
      MODE_BOUNCE: begin
        if (!MULTI_POS) begin
          pos_next_s = position_r;
        end else if (direction_r && (position_r == LAST_POS)) begin
          dir_next_s  = 1'b0;
          pos_next_s  = LAST_POS - POS_ONE;
          turn_next_s = 1'b1;
        end else if (!direction_r && (position_r == POS_ZERO)) begin
          dir_next_s  = 1'b1;
          pos_next_s  = POS_ONE;
          turn_next_s = 1'b1;
        end else if (direction_r) begin
          pos_next_s = position_r + POS_ONE;
        end else begin
          pos_next_s = position_r - POS_ONE;
        end
      end
      MODE_WRAP_UP: begin
        dir_next_s = 1'b1;
        if (position_r == LAST_POS) begin
          pos_next_s  = POS_ZERO;
          turn_next_s = MULTI_POS;
        end else begin
          pos_next_s = position_r + POS_ONE;
        end
      end
      MODE_WRAP_DOWN: begin
        dir_next_s = 1'b0;
        if (position_r == POS_ZERO) begin
          pos_next_s  = LAST_POS;
          turn_next_s = MULTI_POS;
        end else begin
          pos_next_s = position_r - POS_ONE;
        end
      end
      MODE_HOLD: begin
        pos_next_s = position_r;
        dir_next_s = direction_r;
      end
      default: begin
        pos_next_s = position_r;
        dir_next_s = direction_r;
      end
    endcase
  end

  // One-hot decode of the next position so active registers with position.
  always_comb begin
    active_next_s = {NUMBER_DEVICES{1'b0}};
    for (int i = 0; i < NUMBER_DEVICES; i++) begin
      active_next_s[i] = (pos_next_s == POS_W'(i));
    end
  end

  // Output registers: update on tick, strobes cleared otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      position_r  <= POS_ZERO;
      direction_r <= 1'b1;
      active_r    <= ACTIVE_RESET;
      step_r      <= 1'b0;
      turn_r      <= 1'b0;
    end else if (tick_s) begin
      position_r  <= pos_next_s;
      direction_r <= dir_next_s;
      active_r    <= active_next_s;
      step_r      <= 1'b1;
      turn_r      <= turn_next_s;
    end else begin
      position_r  <= position_r;
      direction_r <= direction_r;
      active_r    <= active_r;
      step_r      <= 1'b0;
      turn_r      <= 1'b0;
    end
  end

  assign active    = active_r;
  assign position  = position_r;
  assign direction = direction_r;
  assign step      = step_r;
  assign turn      = turn_r;

endmodule

// File: tb/tb_cylon_scanner.sv
// ---------------------------------------------------------------------------
// tb_cylon_scanner
// Self-checking bench: a 4-position and a 1-position scanner share stimulus.
// A behavioural model is checked every cycle; a vector table and a few
// directed sequences pin down the documented corner cases; a random phase
// finishes the run.
// ---------------------------------------------------------------------------
module tb_cylon_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [29:0] step_clks;
  logic [1:0]  mode;

  logic [3:0]  active4;
  logic [1:0]  pos4;
  logic        dir4, step4, turn4;
  logic [0:0]  active1;
  logic [0:0]  pos1;
  logic        dir1, step1, turn1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cylon_scanner #(.NUMBER_DEVICES(4), .POS_W(2)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .step_clks(step_clks), .mode(mode),
    .active(active4), .position(pos4), .direction(dir4), .step(step4), .turn(turn4)
  );

  cylon_scanner #(.NUMBER_DEVICES(1), .POS_W(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .step_clks(step_clks), .mode(mode),
    .active(active1), .position(pos1), .direction(dir1), .step(step1), .turn(turn1)
  );

  typedef struct packed {
    int pos;
    bit dir;
    int el;
    bit step;
    bit turn;
  } model_t;

  model_t m4, m1;

  // Behavioural model: elapsed enabled cycles vs step length, position moved
  // arithmetically and reflected or taken modulo n.
  function automatic model_t model_next(model_t m, int n, bit r, bit en,
                                        logic [29:0] sc, logic [1:0] md);
    model_t o;
    int lim;
    int p;
    o = m;
    o.step = 1'b0;
    o.turn = 1'b0;
    if (r) begin
      o.pos = 0; o.dir = 1'b1; o.el = 0;
    end else if (en) begin
      o.el = m.el + 1;
      lim = (sc == 30'd0) ? 1 : int'(sc);
      if (o.el >= lim) begin
        o.el = 0;
        o.step = 1'b1;
        case (md)
          2'd0: begin
            if (n > 1) begin
              p = m.pos + (m.dir ? 1 : -1);
              if (p < 0 || p > n - 1) begin
                o.dir = !m.dir;
                p = m.pos + (o.dir ? 1 : -1);
                o.turn = 1'b1;
              end
              o.pos = p;
            end
          end
          2'd1: begin
            o.dir = 1'b1; o.turn = (n > 1) && (m.pos == n - 1); o.pos = (m.pos + 1) % n;
          end
          2'd2: begin
            o.dir = 1'b0; o.turn = (n > 1) && (m.pos == 0); o.pos = (m.pos + n - 1) % n;
          end
          default: ;
        endcase
      end
    end
    return o;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance the models with the inputs presented, then compare.
  task automatic cyc();
    m4 = model_next(m4, 4, rst, enable, step_clks, mode);
    m1 = model_next(m1, 1, rst, enable, step_clks, mode);
    @(posedge clk);
    #1;
    chk("m4.position",  pos4,    m4.pos);
    chk("m4.direction", dir4,    m4.dir);
    chk("m4.active",    active4, longint'(1) << m4.pos);
    chk("m4.step",      step4,   m4.step);
    chk("m4.turn",      turn4,   m4.turn);
    chk("m1.position",  pos1,    m1.pos);
    chk("m1.direction", dir1,    m1.dir);
    chk("m1.active",    active1, 1);
    chk("m1.step",      step1,   m1.step);
    chk("m1.turn",      turn1,   m1.turn);
  endtask

  typedef struct {
    bit          rst;
    bit          en;
    logic [29:0] sc;
    logic [1:0]  md;
    int          pos;
    bit          dir;
    bit          step;
    bit          turn;
  } vec_t;

  vec_t rows[$];

  task automatic add(input bit r, input bit en, input logic [29:0] sc, input logic [1:0] md,
                     input int pos, input bit dir, input bit st, input bit tu);
    vec_t v;
    v.rst = r; v.en = en; v.sc = sc; v.md = md;
    v.pos = pos; v.dir = dir; v.step = st; v.turn = tu;
    rows.push_back(v);
  endtask

  initial begin
    int bp[7];
    bit bd[7];
    bit bt[7];
    int ppos;
    bit pdir;

    m4 = '0; m1 = '0;
    rst = 1'b1; enable = 1'b1; step_clks = 30'd3; mode = 2'd0;

    // ---- vector table: bounce N=4, step 3 -------------------------------
    bp = '{1, 2, 3, 2, 1, 0, 1};
    bd = '{1, 1, 1, 0, 0, 0, 1};
    bt = '{0, 0, 0, 1, 0, 0, 1};
    add(1'b1, 1'b1, 30'd3, 2'd0, 0, 1'b1, 1'b0, 1'b0);
    ppos = 0; pdir = 1'b1;
    for (int k = 0; k < 7; k++) begin
      add(1'b0, 1'b1, 30'd3, 2'd0, ppos, pdir, 1'b0, 1'b0);
      add(1'b0, 1'b1, 30'd3, 2'd0, ppos, pdir, 1'b0, 1'b0);
      add(1'b0, 1'b1, 30'd3, 2'd0, bp[k], bd[k], 1'b1, bt[k]);
      ppos = bp[k]; pdir = bd[k];
    end
    // ---- wrap up at step 1, switch to wrap down, then step_clks = 0 -------
    add(1'b1, 1'b1, 30'd1, 2'd1, 0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 30'd1, 2'd1, 1, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 30'd1, 2'd1, 2, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 30'd1, 2'd1, 3, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 30'd1, 2'd1, 0, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b1, 30'd1, 2'd2, 3, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 30'd1, 2'd2, 2, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 30'd0, 2'd2, 1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 30'd0, 2'd2, 0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 30'd0, 2'd2, 3, 1'b0, 1'b1, 1'b1);

    foreach (rows[i]) begin
      rst = rows[i].rst; enable = rows[i].en; step_clks = rows[i].sc; mode = rows[i].md;
      cyc();
      chk("tbl.position",  pos4,    rows[i].pos);
      chk("tbl.direction", dir4,    rows[i].dir);
      chk("tbl.active",    active4, longint'(1) << rows[i].pos);
      chk("tbl.step",      step4,   rows[i].step);
      chk("tbl.turn",      turn4,   rows[i].turn);
    end

    // ---- step_clks lowered from 100 to 5 at cnt = 50 ---------------------
    rst = 1'b1; enable = 1'b1; step_clks = 30'd100; mode = 2'd0;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cyc();
      chk("slow.no_step", step4, 0);
    end
    step_clks = 30'd5;
    cyc();
    chk("lower.immediate_step", step4, 1);
    chk("lower.position", pos4, 1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("lower.gap", step4, 0);
    end
    cyc();
    chk("lower.period5", step4, 1);
    chk("lower.position2", pos4, 2);

    // ---- enable low for 10 cycles mid-count -------------------------------
    rst = 1'b1; enable = 1'b1; step_clks = 30'd5; mode = 2'd1;
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("frozen.step", step4, 0);
      chk("frozen.position", pos4, 0);
    end
    enable = 1'b1;
    cyc(); chk("resume.wait1", step4, 0);
    cyc(); chk("resume.wait2", step4, 0);
    cyc(); chk("resume.step", step4, 1);
    chk("resume.position", pos4, 1);

    // ---- reset coincident with a tick at position 3, descending ------------
    rst = 1'b1; enable = 1'b1; step_clks = 30'd1; mode = 2'd2;
    cyc();
    rst = 1'b0;
    cyc();
    chk("pre_rst.position", pos4, 3);
    chk("pre_rst.direction", dir4, 0);
    rst = 1'b1;
    cyc();
    chk("rst_tick.position", pos4, 0);
    chk("rst_tick.direction", dir4, 1);
    chk("rst_tick.active", active4, 1);
    chk("rst_tick.step", step4, 0);

    // ---- single position, bounce, step 2 ----------------------------------
    mode = 2'd0; step_clks = 30'd2;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("n1.step", step1, (k % 2 == 1) ? 1 : 0);
      chk("n1.active", active1, 1);
      chk("n1.turn", turn1, 0);
    end

    // ---- randomized phase against the model -------------------------------
    for (int k = 0; k < 2000; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) step_clks = 30'($urandom_range(0, 4));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
